seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 147 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring unsigned divider with start/done handshake.
// Define APPROX_DIV_EN to compute only the upper WIDTH/2 quotient bits.
module sub_half_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

module sub_full_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
`ifdef APPROX_DIV_EN
  localparam int ITERS = WIDTH / 2;
`else
  localparam int ITERS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_q, dsr_q, quo_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_sh, trial, borrow;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt, dvd_nxt;
  logic             no_borrow;

  // WIDTH+1 bit borrow-ripple chain: shifted remainder minus zero-extended divisor
  assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  genvar i;
  generate
    for (i = 0; i <= WIDTH; i++) begin : g_sub
      logic b_bit;
      if (i < WIDTH) begin : g_b
        assign b_bit = dsr_q[i];
      end else begin : g_b0
        assign b_bit = 1'b0;
      end
      if (i == 0) begin : g_h
        sub_half_cell u_cell (.a(rem_sh[i]), .b(b_bit), .d(trial[i]), .bo(borrow[i]));
      end else begin : g_f
        sub_full_cell u_cell (.a(rem_sh[i]), .b(b_bit), .bi(borrow[i-1]),
                              .d(trial[i]), .bo(borrow[i]));
      end
    end
  endgenerate

  assign no_borrow = ~borrow[WIDTH];
  assign rem_nxt   = no_borrow ? trial : rem_sh;
  assign quo_nxt   = {quo_q[WIDTH-2:0], no_borrow};
  assign dvd_nxt   = {dvd_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dsr_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd_q       <= dividend;
          dsr_q       <= divisor;
          quo_q       <= '0;
          rem_q       <= '0;
          cnt_q       <= CW'(ITERS);
          div_by_zero <= 1'b0;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
`ifdef APPROX_DIV_EN
            // Unprocessed low dividend bits sit in the top of the shifted dividend
            quotient  <= quo_nxt << (WIDTH / 2);
            remainder <= {rem_nxt[WIDTH/2-1:0], dvd_nxt[WIDTH-1:WIDTH/2]};
`else
            quotient  <= quo_nxt;
            remainder <= rem_nxt[WIDTH-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed table-driven bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd, dsr, q, r;
    logic         z;
    int           lat, bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Call #1 after a posedge; start is sampled at the next edge.
  task automatic run_div(input vec_t v, input bit glitch);
    int edges = 0;
    int busy_cnt = 0;
    start = 1'b1; dividend = v.dvd; divisor = v.dsr;
    @(posedge clk); edges = 1; #1;
    start = 1'b0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      start = glitch && (edges == 3);
      if (start) begin dividend = 8'd200; divisor = 8'd50; end
      @(posedge clk); edges++; #1;
    end
    start = 1'b0;
    chk($sformatf("lat %0d/%0d", v.dvd, v.dsr), edges, v.lat);
    chk($sformatf("quo %0d/%0d", v.dvd, v.dsr), quotient, v.q);
    chk($sformatf("rem %0d/%0d", v.dvd, v.dsr), remainder, v.r);
    chk($sformatf("dbz %0d/%0d", v.dvd, v.dsr), div_by_zero, v.z);
    chk($sformatf("busy_cycles %0d/%0d", v.dvd, v.dsr), busy_cnt, v.bsy);
    @(posedge clk); #1;
    chk($sformatf("done_width %0d/%0d", v.dvd, v.dsr), done, 0);
  endtask

  initial begin
    int done_seen;
    vec_t v;
`ifdef APPROX_DIV_EN
    vecs.push_back('{8'd200, 8'd3,   8'd64,  8'd8,   1'b0, 5, 4});
    vecs.push_back('{8'd100, 8'd7,   8'd0,   8'd100, 1'b0, 5, 4});
    vecs.push_back('{8'd255, 8'd1,   8'd240, 8'd15,  1'b0, 5, 4});
    vecs.push_back('{8'd77,  8'd0,   8'd255, 8'd77,  1'b1, 1, 0});
    vecs.push_back('{8'd10,  8'd3,   8'd0,   8'd10,  1'b0, 5, 4});
`else
    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 8});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 8});
    vecs.push_back('{8'd77,  8'd0,   8'd255, 8'd77,  1'b1, 1, 0});
    vecs.push_back('{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9, 8});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 8});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9, 8});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9, 8});
`endif

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quo", quotient, 0);
    chk("reset_rem", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: each divide starts in the IDLE cycle after the previous done
    for (int k = 0; k < vecs.size(); k++) run_div(vecs[k], 1'b0);

    // Mid-CALC start with different operands must be ignored
    run_div(vecs[0], 1'b1);

`ifndef APPROX_DIV_EN
    // Async reset on the 4th CALC cycle aborts with no done
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quo", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    done_seen = 0;
    repeat (3) begin @(posedge clk); #1; done_seen += done; end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; done_seen += done; end
    chk("abort_no_done", done_seen, 0);
    v = '{8'd12, 8'd4, 8'd3, 8'd0, 1'b0, 9, 8};
    run_div(v, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
